trace_sink: RTL and testbench
=============================

# trace_sink

Receiving end of the core's trace port. Captures 36-bit trace words (`trace_valid` / `trace_data`) into a FIFO and presents them on a ready/valid read port for a debug host or bus bridge. Counts and flags words dropped on overflow. Sits beside the CPU core, clocked from the same domain.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `DROP_W`, 16, width of the saturating drop counter.
- `clk`  in  1  core clock; all logic on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `trace_valid`  in  1  trace word present this cycle (no back-pressure on the core).
- `trace_data`  in  36  trace word: [35:32] flags (0001 branch, 0010 address, 1000 irq), [31:0] payload.
- `enable`  in  1  capture enable.
- `stop_on_full`  in  1  freeze capture at the first dropped word.
- `clear`  in  1  synchronous flush: empties FIFO, clears `overflow`, `drop_count` and the frozen state.
- `out_valid`  out  1  head word available.
- `out_data`  out  36  head word.
- `out_ready`  in  1  consumer accepts the head word.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set on any dropped word.
- `drop_count`  out  DROP_W  dropped words, saturating at all-ones.
- `frozen`  out  1  capture stopped by `stop_on_full`.

## Operation
- FSM states:
  - IDLE: `enable`=0.
  - RUN: `enable`=1, not frozen.
  - FROZEN.
- Transitions:
  - IDLE↔RUN follows `enable`.
  - RUN→FROZEN on a drop while `stop_on_full`=1.
  - FROZEN→IDLE/RUN only on `clear`.
- Push: in RUN, `trace_valid`=1 and `level`<DEPTH. The word is written unmodified.
- Drop: in RUN, `trace_valid`=1 and `level`=DEPTH.
  - Sets `overflow` and increments `drop_count`; the counter never wraps.
  - Fullness is judged on the pre-pop level. A pop in the same cycle does not make room, so the word is still dropped.
- `trace_valid` in IDLE or FROZEN is ignored and not counted.
- Pop: `out_valid`=1 and `out_ready`=1. Reading continues in every state, including FROZEN.
- Simultaneous push and pop when not full: both happen and `level` is unchanged.
- Read and write pointers are ADDR_W = $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is derived from an extra wrap bit.
- `clear` has priority over push, pop, and the FSM. Words presented in the `clear` cycle are discarded and not counted.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0, `drop_count`=0, `frozen`=0, FSM=IDLE.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous).
- Write-to-read latency is 1 cycle: a word pushed at edge N into an empty FIFO gives `out_valid`=1 with that word after edge N.
- `out_data` is registered.
  - Stable while `out_valid`=1 and `out_ready`=0.
  - Next word appears the cycle after a pop, giving full throughput of 1 word/cycle.
- `level`, `overflow`, `drop_count` and `frozen` update on the same edge as the causing event.
- `enable` takes effect on the first edge where it is sampled high.

## Configuration
- `TRACE_SINK_STATS_EN` defined: adds outputs `branch_count`, `addr_count` and `irq_count` (32-bit each).
  - Each counts pushed (not dropped) words whose flag bit 32, 33 or 35 respectively is set.
  - Counters wrap modulo 2^32, reset to 0, and are cleared by `clear`.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `trace_pkg`:
  - `TRACE_W`=36.
  - Flag bit positions and values (`TRACE_FLAG_BRANCH`, `TRACE_FLAG_ADDR`, `TRACE_FLAG_IRQ`).
  - FSM state enum `trace_sink_state_t` {IDLE, RUN, FROZEN}.
- Sub-module `trace_fifo`: synchronous single-clock FIFO with registered output, `level` and full/empty.
- `trace_sink` holds the FSM, the drop logic and the optional stats.

## Test plan
- Reset, `enable`=1, push 3 words (0x1_00000010, 0x2_00000020, 0x8_00000030) with `out_ready`=0 → `level`=3, `out_data`=0x1_00000010. Then hold `out_ready`=1 → the three words out in order on consecutive cycles, `level`=0.
- DEPTH=16, `out_ready`=0, 20 pushes → `level`=16, `overflow`=1, `drop_count`=4, first 16 words intact on readout.
- Full FIFO, `trace_valid`=1 and `out_ready`=1 in the same cycle → word dropped, `drop_count`+1, `level`=15.
- `stop_on_full`=1, overflow by 1 → `frozen`=1; further pushes ignored with `drop_count` fixed at 1; draining still works. Then `clear` → `frozen`=0, `level`=0, `drop_count`=0.
- DROP_W=4, 40 drops → `drop_count`=15 (saturated).
- With `TRACE_SINK_STATS_EN`: push flags 0001, 0001, 1000, 0010 → `branch_count`=2, `irq_count`=1, `addr_count`=1. Assert `resetn` low mid-stream → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/trace_pkg.sv
// ============================================================================
// Module      : trace_pkg
// Description : Shared trace word width, flag encodings and sink FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

  localparam int TRACE_W = 36;

  // Flag nibble occupies trace_data[35:32]
  localparam int TRACE_FLAG_BRANCH_BIT = 32;
  localparam int TRACE_FLAG_ADDR_BIT   = 33;
  localparam int TRACE_FLAG_IRQ_BIT    = 35;

  localparam logic [3:0] TRACE_FLAG_BRANCH = 4'b0001;
  localparam logic [3:0] TRACE_FLAG_ADDR   = 4'b0010;
  localparam logic [3:0] TRACE_FLAG_IRQ    = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } trace_sink_state_t;

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// Module      : trace_fifo
// Description : Single-clock FIFO with registered head word, occupancy and full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_ready_i,
  output logic                       rvalid_o,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              rvalid_q;
  logic [WIDTH-1:0]  rdata_q;
  logic [ADDR_W:0]   w_level, w_level_d;
  logic              w_full, w_push, w_pop;
  logic [WIDTH-1:0]  w_head_d;

  assign w_level = wr_ptr_q - rd_ptr_q;
  assign w_full  = (w_level == FULL_LVL);
  assign w_push  = push_i & ~w_full & ~clear_i;
  assign w_pop   = rvalid_q & pop_ready_i & ~clear_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + (ADDR_W+1)'(w_push);
    rd_ptr_d  = rd_ptr_q + (ADDR_W+1)'(w_pop);
    w_level_d = wr_ptr_d - rd_ptr_d;
    // The new head is the word being written this edge when it lands at the read slot
    if (w_push && (rd_ptr_d == wr_ptr_q)) begin
      w_head_d = wdata_i;
    end else begin
      w_head_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rvalid_q <= (w_level_d != '0);
      if (w_level_d != '0) begin
        rdata_q <= w_head_d;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign level_o  = w_level;
  assign full_o   = w_full;

endmodule

`default_nettype wire

// File: rtl/trace_sink.sv
// ============================================================================
// Module      : trace_sink
// Description : Trace port capture FIFO with drop accounting and freeze-on-full.
//               Define TRACE_SINK_STATS_EN to add per-flag push counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_sink
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     trace_valid,
  input  logic [TRACE_W-1:0]       trace_data,
  input  logic                     enable,
  input  logic                     stop_on_full,
  input  logic                     clear,
  output logic                     out_valid,
  output logic [TRACE_W-1:0]       out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
`ifdef TRACE_SINK_STATS_EN
  output logic [31:0]              branch_count,
  output logic [31:0]              addr_count,
  output logic [31:0]              irq_count,
`endif
  output logic                     frozen
);

  trace_sink_state_t state_q, state_d;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_count_q;
  logic              w_full, w_capture, w_push, w_drop;

  // Capture starts on the very edge enable is first sampled high
  assign w_capture = enable & (state_q != FROZEN) & ~clear;
  assign w_push    = w_capture & trace_valid & ~w_full;
  assign w_drop    = w_capture & trace_valid & w_full;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .clear_i     (clear),
    .push_i      (w_push),
    .wdata_i     (trace_data),
    .pop_ready_i (out_ready),
    .rvalid_o    (out_valid),
    .rdata_o     (out_data),
    .level_o     (level),
    .full_o      (w_full)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = enable ? RUN : IDLE;
    end else if (w_drop && stop_on_full) begin
      state_d = FROZEN;
    end else if (state_q != FROZEN) begin
      state_d = enable ? RUN : IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        overflow_q   <= 1'b0;
        drop_count_q <= '0;
      end else if (w_drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != '1) begin
          drop_count_q <= drop_count_q + 1'b1;
        end
      end
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign frozen     = (state_q == FROZEN);

`ifdef TRACE_SINK_STATS_EN
  logic [31:0] branch_cnt_q, addr_cnt_q, irq_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branch_cnt_q <= '0;
      addr_cnt_q   <= '0;
      irq_cnt_q    <= '0;
    end else if (clear) begin
      branch_cnt_q <= '0;
      addr_cnt_q   <= '0;
      irq_cnt_q    <= '0;
    end else if (w_push) begin
      branch_cnt_q <= branch_cnt_q + 32'(trace_data[TRACE_FLAG_BRANCH_BIT]);
      addr_cnt_q   <= addr_cnt_q   + 32'(trace_data[TRACE_FLAG_ADDR_BIT]);
      irq_cnt_q    <= irq_cnt_q    + 32'(trace_data[TRACE_FLAG_IRQ_BIT]);
    end
  end

  assign branch_count = branch_cnt_q;
  assign addr_count   = addr_cnt_q;
  assign irq_count    = irq_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trace_sink.sv
// ============================================================================
// Module      : tb_trace_sink
// Description : Directed self-checking bench for trace_sink (DEPTH=16 instance
//               plus a DROP_W=4 instance for counter saturation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_sink;

  logic        clk;
  logic        resetn;
  logic        trace_valid;
  logic [35:0] trace_data;
  logic        enable;
  logic        stop_on_full;
  logic        clear;
  logic        out_ready;

  logic        out_valid,  out_valid4;
  logic [35:0] out_data,   out_data4;
  logic [4:0]  level,      level4;
  logic        overflow,   overflow4;
  logic [15:0] drop_count;
  logic [3:0]  drop_count4;
  logic        frozen,     frozen4;
`ifdef TRACE_SINK_STATS_EN
  logic [31:0] branch_count, addr_count, irq_count;
  logic [31:0] branch_count4, addr_count4, irq_count4;
`endif

  int checks;
  int failures;

  trace_sink #(.DEPTH(16), .DROP_W(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .trace_valid  (trace_valid),
    .trace_data   (trace_data),
    .enable       (enable),
    .stop_on_full (stop_on_full),
    .clear        (clear),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count),
`ifdef TRACE_SINK_STATS_EN
    .branch_count (branch_count),
    .addr_count   (addr_count),
    .irq_count    (irq_count),
`endif
    .frozen       (frozen)
  );

  trace_sink #(.DEPTH(16), .DROP_W(4)) dut4 (
    .clk          (clk),
    .resetn       (resetn),
    .trace_valid  (trace_valid),
    .trace_data   (trace_data),
    .enable       (enable),
    .stop_on_full (stop_on_full),
    .clear        (clear),
    .out_valid    (out_valid4),
    .out_data     (out_data4),
    .out_ready    (out_ready),
    .level        (level4),
    .overflow     (overflow4),
    .drop_count   (drop_count4),
`ifdef TRACE_SINK_STATS_EN
    .branch_count (branch_count4),
    .addr_count   (addr_count4),
    .irq_count    (irq_count4),
`endif
    .frozen       (frozen4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    trace_valid = 1'b0;
    out_ready   = 1'b0;
    clear       = 1'b1;
    tick();
    clear       = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; trace_valid = 1'b0; trace_data = '0; enable = 1'b0;
    stop_on_full = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 36'h0 || level !== 5'd0 || overflow !== 1'b0 ||
        drop_count !== 16'd0 || frozen !== 1'b0) begin
      failures++;
      $display("FAIL reset: valid=%b data=%h level=%0d ovf=%b drop=%0d frz=%b, required all zero",
               out_valid, out_data, level, overflow, drop_count, frozen);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [35:0] w [3];
    w[0] = 36'h1_00000010; w[1] = 36'h2_00000020; w[2] = 36'h8_00000030;
    do_clear();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      trace_valid = 1'b1; trace_data = w[i];
      tick();
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== w[0]) begin
          failures++;
          $display("FAIL latency: valid=%b data=%h, required 1 %h", out_valid, out_data, w[0]);
        end
      end
    end
    trace_valid = 1'b0;
    checks++;
    if (level !== 5'd3 || out_data !== w[0]) begin
      failures++;
      $display("FAIL basic_fill: level=%0d data=%h, required 3 %h", level, out_data, w[0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i]) begin
        failures++;
        $display("FAIL basic_read%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data, w[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_empty: level=%0d valid=%b, required 0 0", level, out_valid);
    end
  endtask

  task automatic test_overflow_and_full_pop();
    do_clear();
    for (int i = 0; i < 20; i++) begin
      trace_valid = 1'b1; trace_data = {4'h2, 32'(i + 100)};
      tick();
    end
    trace_valid = 1'b0;
    checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 16'd4 || drop_count4 !== 4'd4) begin
      failures++;
      $display("FAIL overflow: level=%0d ovf=%b drop=%0d drop4=%0d, required 16 1 4 4",
               level, overflow, drop_count, drop_count4);
    end
    checks++;
    if (out_data !== {4'h2, 32'd100}) begin
      failures++;
      $display("FAIL overflow_head: data=%h, required %h", out_data, {4'h2, 32'd100});
    end
    // Push against a full FIFO while popping: the push is still dropped
    trace_valid = 1'b1; trace_data = 36'hF_FFFFFFFF; out_ready = 1'b1;
    tick();
    trace_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (drop_count !== 16'd5 || level !== 5'd15) begin
      failures++;
      $display("FAIL full_pop: drop=%0d level=%0d, required 5 15", drop_count, level);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== {4'h2, 32'(i + 100)}) begin
        failures++;
        $display("FAIL drain%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data,
                 {4'h2, 32'(i + 100)});
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: level=%0d valid=%b, required 0 0", level, out_valid);
    end
  endtask

  task automatic test_stop_on_full();
    do_clear();
    stop_on_full = 1'b1;
    for (int i = 0; i < 17; i++) begin
      trace_valid = 1'b1; trace_data = {4'h1, 32'(i)};
      tick();
    end
    checks++;
    if (frozen !== 1'b1 || drop_count !== 16'd1 || level !== 5'd16) begin
      failures++;
      $display("FAIL freeze: frz=%b drop=%0d level=%0d, required 1 1 16", frozen, drop_count, level);
    end
    tick(); tick(); tick();
    checks++;
    if (frozen !== 1'b1 || drop_count !== 16'd1 || level !== 5'd16) begin
      failures++;
      $display("FAIL frozen_ignore: frz=%b drop=%0d level=%0d, required 1 1 16", frozen, drop_count, level);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (level !== 5'd0 || frozen !== 1'b1 || drop_count !== 16'd1) begin
      failures++;
      $display("FAIL frozen_drain: level=%0d frz=%b drop=%0d, required 0 1 1", level, frozen, drop_count);
    end
    stop_on_full = 1'b0;
    do_clear();
    checks++;
    if (frozen !== 1'b0 || level !== 5'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL unfreeze: frz=%b level=%0d drop=%0d ovf=%b, required 0 0 0 0",
               frozen, level, drop_count, overflow);
    end
  endtask

  task automatic test_saturate();
    do_clear();
    for (int i = 0; i < 56; i++) begin
      trace_valid = 1'b1; trace_data = {4'h8, 32'(i)};
      tick();
    end
    trace_valid = 1'b0;
    checks++;
    if (drop_count4 !== 4'd15 || drop_count !== 16'd40 || overflow4 !== 1'b1) begin
      failures++;
      $display("FAIL saturate: drop4=%0d drop16=%0d ovf4=%b, required 15 40 1",
               drop_count4, drop_count, overflow4);
    end
  endtask

  task automatic test_ignored_inputs();
    do_clear();
    // Words presented during clear and while disabled must vanish uncounted
    trace_valid = 1'b1; trace_data = 36'h1_12345678; clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b0;
    tick(); tick();
    trace_valid = 1'b0;
    checks++;
    if (level !== 5'd0 || drop_count !== 16'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignored: level=%0d drop=%0d valid=%b, required 0 0 0", level, drop_count, out_valid);
    end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    do_clear();
    trace_valid = 1'b1; trace_data = 36'h2_00000000;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      trace_data = {4'h2, 32'(i)};
      tick();
      checks++;
      if (level !== 5'd1 || out_data !== {4'h2, 32'(i)}) begin
        failures++;
        $display("FAIL b2b%0d: level=%0d data=%h, required 1 %h", i, level, out_data, {4'h2, 32'(i)});
      end
    end
    trace_valid = 1'b0; out_ready = 1'b0;
  endtask

`ifdef TRACE_SINK_STATS_EN
  task automatic test_stats();
    logic [3:0] f [4];
    f[0] = 4'b0001; f[1] = 4'b0001; f[2] = 4'b1000; f[3] = 4'b0010;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      trace_valid = 1'b1; trace_data = {f[i], 32'(i)};
      tick();
    end
    trace_valid = 1'b0;
    checks++;
    if (branch_count !== 32'd2 || irq_count !== 32'd1 || addr_count !== 32'd1) begin
      failures++;
      $display("FAIL stats: br=%0d irq=%0d addr=%0d, required 2 1 1", branch_count, irq_count, addr_count);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 5; i++) begin
      trace_valid = 1'b1; trace_data = {4'h1, 32'(i)};
      tick();
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 36'h0 || level !== 5'd0 || overflow !== 1'b0 ||
        drop_count !== 16'd0 || frozen !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b data=%h level=%0d ovf=%b drop=%0d frz=%b, required all zero",
               out_valid, out_data, level, overflow, drop_count, frozen);
    end
`ifdef TRACE_SINK_STATS_EN
    checks++;
    if (branch_count !== 32'd0 || addr_count !== 32'd0 || irq_count !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_stats: br=%0d addr=%0d irq=%0d, required 0 0 0",
               branch_count, addr_count, irq_count);
    end
`endif
    trace_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_overflow_and_full_pop();
    test_stop_on_full();
    test_saturate();
    test_ignored_inputs();
    test_back_to_back();
`ifdef TRACE_SINK_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
